// File: rtl/ahbl_sram_stall.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahbl_sram_stall - AHB-Lite SRAM slave with per-transfer programmable wait
// states; error injection enabled by defining AHBL_SRAM_STALL_ERR_INJECT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ahbl_sram_stall #(
  parameter int DEPTH  = 1024,
  parameter int W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [31:0]       ahbls_hwdata,
  output logic [31:0]       ahbls_hrdata,
  input  logic [3:0]        stall_cycles
`ifdef AHBL_SRAM_STALL_ERR_INJECT_EN
  ,
  input  logic              err_req
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;

  logic [AW-1:0] dp_idx;
  logic [3:0]    dp_mask;
  logic          dp_write;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH];

  logic          err_in;
  logic          completing;
  logic          accept;
  logic [AW-1:0] a_idx;
  logic [3:0]    a_mask;
  logic          wr_en;
  logic [31:0]   wr_merged;
  logic [31:0]   rd_word;
  logic          unused;

`ifdef AHBL_SRAM_STALL_ERR_INJECT_EN
  assign err_in = err_req;
`else
  assign err_in = 1'b0;
`endif

  assign unused = ^{ahbls_haddr[W_ADDR-1:AW+2], ahbls_htrans[0]};

  // The data phase in flight finishes this cycle; only then can a new address
  // phase be taken, which is what gives back-to-back transfers with no bubble.
  assign completing = (state == IDLE) || (state == ERR2) ||
                      ((state == WAIT) && (cnt == 4'd0));

  assign accept = !rst && completing && ahbls_hready && ahbls_htrans[1];
  assign a_idx  = ahbls_haddr[AW+1:2];

  // Misaligned halfwords and sizes above a word collapse to a full-word access.
  always_comb begin
    a_mask = 4'b1111;
    if (ahbls_hsize == 3'd0) begin
      a_mask = 4'b0001 << ahbls_haddr[1:0];
    end else if ((ahbls_hsize == 3'd1) && !ahbls_haddr[0]) begin
      a_mask = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign wr_en = !rst && dp_write && completing;

  always_comb begin
    wr_merged = mem[dp_idx];
    for (int i = 0; i < 4; i++) begin
      if (dp_mask[i]) begin
        wr_merged[8*i +: 8] = ahbls_hwdata[8*i +: 8];
      end
    end
  end

  // A read taken while a write to the same word retires sees the merged word.
  assign rd_word = (wr_en && (dp_idx == a_idx)) ? wr_merged : mem[a_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ERR1:    state_nxt = ERR2;
      default: ;
    endcase
    if (completing) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
      if (accept) begin
        if (err_in) begin
          state_nxt = ERR1;
        end else if (stall_cycles != 4'd0) begin
          state_nxt = WAIT;
          cnt_nxt   = stall_cycles;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_idx   <= '0;
      dp_mask  <= 4'd0;
      dp_write <= 1'b0;
      rdata_q  <= 32'd0;
    end else if (completing) begin
      dp_write <= accept && ahbls_hwrite && !err_in;
      if (accept) begin
        dp_idx  <= a_idx;
        dp_mask <= a_mask;
        rdata_q <= (ahbls_hwrite || err_in) ? 32'd0 : rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && dp_mask[i]) begin
        mem[dp_idx][8*i +: 8] <= ahbls_hwdata[8*i +: 8];
      end
    end
  end

  assign ahbls_hready_resp = rst || completing;
  assign ahbls_hrdata      = rst ? 32'd0 : rdata_q;
`ifdef AHBL_SRAM_STALL_ERR_INJECT_EN
  assign ahbls_hresp = !rst && ((state == ERR1) || (state == ERR2));
`else
  assign ahbls_hresp = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahbl_sram_stall.sv
`default_nettype none
// tb_ahbl_sram_stall - directed vector table plus hand-written reset and
// error-injection sequences for ahbl_sram_stall.
module tb_ahbl_sram_stall;

  logic        clk;
  logic        rst;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hready;
  logic        hready_resp;
  logic        hresp;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [3:0]  stall;
`ifdef AHBL_SRAM_STALL_ERR_INJECT_EN
  logic        err_req;
`endif

  int checks = 0;
  int errors = 0;

  ahbl_sram_stall #(.DEPTH(1024), .W_ADDR(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .ahbls_haddr      (haddr),
    .ahbls_hwrite     (hwrite),
    .ahbls_htrans     (htrans),
    .ahbls_hsize      (hsize),
    .ahbls_hready     (hready),
    .ahbls_hready_resp(hready_resp),
    .ahbls_hresp      (hresp),
    .ahbls_hwdata     (hwdata),
    .ahbls_hrdata     (hrdata),
    .stall_cycles     (stall)
`ifdef AHBL_SRAM_STALL_ERR_INJECT_EN
    ,
    .err_req          (err_req)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hready;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  stall;
    logic        err;
    logic        erdy;
    logic        eresp;
    logic        chk;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic hr, input logic [1:0] tr,
                              input logic wr, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] st, input logic er,
                              input logic erdy, input logic eresp, input logic chk,
                              input logic [31:0] erd);
    vec_t v;
    v.rst = r; v.hready = hr; v.trans = tr; v.write = wr; v.size = sz; v.addr = a;
    v.wdata = wd; v.stall = st; v.err = er; v.erdy = erdy; v.eresp = eresp;
    v.chk = chk; v.erd = erd;
    return v;
  endfunction

  // Apply one cycle of inputs, compare outputs mid-cycle, advance past the edge.
  task automatic step(input string tag, input vec_t v);
    rst = v.rst; hready = v.hready; htrans = v.trans; hwrite = v.write;
    hsize = v.size; haddr = v.addr; hwdata = v.wdata; stall = v.stall;
`ifdef AHBL_SRAM_STALL_ERR_INJECT_EN
    err_req = v.err;
`endif
    @(negedge clk);
    checks++;
    if (hready_resp !== v.erdy) begin
      errors++;
      $display("FAIL %s hready_resp got %0b exp %0b", tag, hready_resp, v.erdy);
    end
    checks++;
    if (hresp !== v.eresp) begin
      errors++;
      $display("FAIL %s hresp got %0b exp %0b", tag, hresp, v.eresp);
    end
    if (v.chk) begin
      checks++;
      if (hrdata !== v.erd) begin
        errors++;
        $display("FAIL %s hrdata got %08h exp %08h", tag, hrdata, v.erd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[30];

  initial begin
    rst = 1'b1; hready = 1'b1; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
    haddr = 32'd0; hwdata = 32'd0; stall = 4'd0;
`ifdef AHBL_SRAM_STALL_ERR_INJECT_EN
    err_req = 1'b0;
`endif
    //              rst hr tr   wr sz  addr       wdata         st er rdy rsp chk rdata
    tbl[0]  = mk(1, 1, 2'd0, 0, 3'd0, 32'h0,    32'h0,        0, 0, 1, 0, 1, 32'h0);
    tbl[1]  = mk(1, 1, 2'd0, 0, 3'd0, 32'h0,    32'h0,        0, 0, 1, 0, 1, 32'h0);
    tbl[2]  = mk(0, 1, 2'd2, 1, 3'd2, 32'h10,   32'h0,        0, 0, 1, 0, 1, 32'h0);
    tbl[3]  = mk(0, 1, 2'd2, 0, 3'd2, 32'h10,   32'hDEADBEEF, 0, 0, 1, 0, 0, 32'h0);
    tbl[4]  = mk(0, 1, 2'd0, 0, 3'd2, 32'h0,    32'h0,        0, 0, 1, 0, 1, 32'hDEADBEEF);
    tbl[5]  = mk(0, 1, 2'd2, 1, 3'd2, 32'h20,   32'h0,        0, 0, 1, 0, 0, 32'h0);
    tbl[6]  = mk(0, 1, 2'd2, 0, 3'd2, 32'h20,   32'hCAFEF00D, 3, 0, 1, 0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 2'd0, 0, 3'd0, 32'h0,    32'h0,        0, 0, 0, 0, 1, 32'hCAFEF00D);
    tbl[8]  = mk(0, 0, 2'd0, 0, 3'd0, 32'h0,    32'h0,        0, 0, 0, 0, 1, 32'hCAFEF00D);
    tbl[9]  = mk(0, 0, 2'd0, 0, 3'd0, 32'h0,    32'h0,        0, 0, 0, 0, 1, 32'hCAFEF00D);
    tbl[10] = mk(0, 1, 2'd2, 1, 3'd2, 32'h8,    32'h0,        0, 0, 1, 0, 1, 32'hCAFEF00D);
    tbl[11] = mk(0, 1, 2'd2, 1, 3'd0, 32'hA,    32'h11223344, 0, 0, 1, 0, 0, 32'h0);
    tbl[12] = mk(0, 1, 2'd2, 0, 3'd2, 32'h8,    32'hFFAAFFFF, 0, 0, 1, 0, 0, 32'h0);
    tbl[13] = mk(0, 1, 2'd2, 1, 3'd1, 32'hA,    32'h0,        0, 0, 1, 0, 1, 32'h11AA3344);
    tbl[14] = mk(0, 1, 2'd2, 0, 3'd2, 32'h8,    32'h7788FFFF, 0, 0, 1, 0, 0, 32'h0);
    tbl[15] = mk(0, 1, 2'd2, 1, 3'd2, 32'h4,    32'h0,        0, 0, 1, 0, 1, 32'h77883344);
    tbl[16] = mk(0, 1, 2'd2, 0, 3'd2, 32'h4,    32'h5A5A5A5A, 0, 0, 1, 0, 0, 32'h0);
    tbl[17] = mk(0, 1, 2'd2, 0, 3'd2, 32'h1008, 32'h0,        1, 0, 1, 0, 1, 32'h5A5A5A5A);
    tbl[18] = mk(0, 0, 2'd0, 0, 3'd0, 32'h0,    32'h0,        0, 0, 0, 0, 1, 32'h77883344);
    tbl[19] = mk(0, 1, 2'd2, 1, 3'd2, 32'h4,    32'h0,        2, 0, 1, 0, 1, 32'h77883344);
    tbl[20] = mk(0, 0, 2'd0, 0, 3'd0, 32'h0,    32'h0BADBAD0, 0, 0, 0, 0, 0, 32'h0);
    tbl[21] = mk(0, 0, 2'd0, 0, 3'd0, 32'h0,    32'h0BADBAD0, 0, 0, 0, 0, 0, 32'h0);
    tbl[22] = mk(0, 1, 2'd2, 0, 3'd2, 32'h4,    32'h13572468, 0, 0, 1, 0, 0, 32'h0);
    tbl[23] = mk(0, 1, 2'd2, 1, 3'd1, 32'h11,   32'h0,        0, 0, 1, 0, 1, 32'h13572468);
    tbl[24] = mk(0, 1, 2'd2, 0, 3'd3, 32'h10,   32'h24681357, 0, 0, 1, 0, 0, 32'h0);
    tbl[25] = mk(0, 1, 2'd1, 0, 3'd2, 32'h40,   32'h0,        0, 0, 1, 0, 1, 32'h24681357);
    tbl[26] = mk(0, 1, 2'd2, 0, 3'd2, 32'h20,   32'h0,        5, 0, 1, 0, 0, 32'h0);
    tbl[27] = mk(0, 0, 2'd0, 0, 3'd0, 32'h0,    32'h0,        0, 0, 0, 0, 1, 32'hCAFEF00D);
    tbl[28] = mk(1, 0, 2'd0, 0, 3'd0, 32'h0,    32'h0,        0, 0, 1, 0, 1, 32'h0);
    tbl[29] = mk(0, 1, 2'd2, 0, 3'd2, 32'h4,    32'h0,        0, 0, 1, 0, 1, 32'h0);

    for (int i = 0; i < 30; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset landing on the completing cycle of a stalled write must drop it.
    step("rstwr0", mk(0, 1, 2'd2, 1, 3'd2, 32'h4, 32'h0,        1, 0, 1, 0, 1, 32'h13572468));
    step("rstwr1", mk(0, 0, 2'd0, 0, 3'd0, 32'h0, 32'hDEAD0000, 0, 0, 0, 0, 0, 32'h0));
    step("rstwr2", mk(1, 0, 2'd0, 0, 3'd0, 32'h0, 32'hFFFFFFFF, 0, 0, 1, 0, 1, 32'h0));
    step("rstwr3", mk(0, 1, 2'd2, 0, 3'd2, 32'h4, 32'h0,        0, 0, 1, 0, 1, 32'h0));
    step("rstwr4", mk(0, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0,        0, 0, 1, 0, 1, 32'h13572468));

`ifdef AHBL_SRAM_STALL_ERR_INJECT_EN
    step("err0", mk(0, 1, 2'd2, 1, 3'd2, 32'h0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
    step("err1", mk(0, 1, 2'd2, 1, 3'd2, 32'h0, 32'h0BEEF000, 3, 1, 1, 0, 0, 32'h0));
    step("err2", mk(0, 0, 2'd0, 0, 3'd0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 32'h0));
    step("err3", mk(0, 1, 2'd2, 0, 3'd2, 32'h0, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 32'h0));
    step("err4", mk(0, 1, 2'd2, 0, 3'd2, 32'h0, 32'h0,        0, 1, 1, 0, 1, 32'h0BEEF000));
    step("err5", mk(0, 0, 2'd0, 0, 3'd0, 32'h0, 32'h0,        0, 0, 0, 1, 1, 32'h0));
    step("err6", mk(0, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0,        0, 0, 1, 1, 1, 32'h0));
    step("err7", mk(0, 1, 2'd0, 0, 3'd0, 32'h0, 32'h0,        0, 0, 1, 0, 0, 32'h0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
